// File: rtl/fpu_mul_param.sv
// Parametrised floating-point multiply coprocessor.
// Shift-add significand multiply, RNE rounding, flush-to-zero underflow.
module fpu_mul_param #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXPW+FRACW:0]   fpuIn1,
  input  logic [EXPW+FRACW:0]   fpuIn2,
  output logic [EXPW+FRACW:0]   fpuOut,
  output logic                  done,
  output logic                  busy,
  output logic [3:0]            condCodes
);

  localparam int W    = 1 + EXPW + FRACW;
  localparam int SW   = FRACW + 1;
  localparam int PW   = 2 * SW;
  localparam int LW   = $clog2(PW);
  localparam int CW   = $clog2(SW);
  localparam int EW   = EXPW + LW + 3;
  localparam int BIAS = (1 << (EXPW - 1)) - 1;
  localparam int EMAX = (1 << EXPW) - 1;

  localparam logic signed [EW-1:0] ONE   = 1;
  localparam logic signed [EW-1:0] EMAXS = EMAX;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [SW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic [3:0]    cc_q, cc_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [SW-1:0] man_in1, man_in2;
  logic [W-1:0]  res;
  logic [3:0]    res_cc;

  assign fpuOut    = out_q;
  assign condCodes = cc_q;
  assign done      = done_q;
  assign busy      = busy_q;

  // Significands of the live inputs; hidden bit is 0 for exp==0.
  always_comb begin
    man_in1 = {|fpuIn1[W-2:FRACW], fpuIn1[FRACW-1:0]};
    man_in2 = {|fpuIn2[W-2:FRACW], fpuIn2[FRACW-1:0]};
  end

  // Normalise, round and resolve special operands from the product.
  always_comb begin
    logic                 sa, sb, sgn;
    logic [EXPW-1:0]      xa, xb;
    logic [FRACW-1:0]     fa, fb;
    logic                 nan_a, nan_b;
    logic                 inf_a, inf_b;
    logic                 zero_a, zero_b;
    logic signed [EW-1:0] ea, eb, e_n, e_r;
    logic [LW-1:0]        pos, sh;
    logic [PW-1:0]        norm;
    logic [FRACW-1:0]     frac_t;
    logic                 g, r, s, ru, inex, nz;
    logic [FRACW:0]       rsum;
    logic [W-1:0]         qnan;

    {sa, xa, fa} = a_q;
    {sb, xb, fb} = b_q;
    sgn    = sa ^ sb;
    nan_a  = (&xa) & (|fa);
    nan_b  = (&xb) & (|fb);
    inf_a  = (&xa) & ~(|fa);
    inf_b  = (&xb) & ~(|fb);
    zero_a = ~(|xa) & ~(|fa);
    zero_b = ~(|xb) & ~(|fb);
    ea     = (xa == '0) ? ONE : EW'(xa);
    eb     = (xb == '0) ? ONE : EW'(xb);

    pos = '0;
    for (int i = 0; i < PW; i++) begin
      if (acc_q[i]) pos = LW'(i);
    end
    sh   = LW'(PW - 1) - pos;
    norm = acc_q << sh;
    nz   = norm[PW-1];
    e_n  = ea + eb - EW'(BIAS)
         + EW'(pos) - EW'(PW - 2);

    frac_t = norm[PW-2 -: FRACW];
    g      = norm[FRACW];
    r      = norm[FRACW-1];
    s      = |norm[FRACW-2:0];
    inex   = g | r | s;
    ru     = g & (r | s | frac_t[0]);
    rsum   = {1'b0, frac_t} + {{FRACW{1'b0}}, ru};
    e_r    = e_n + EW'(rsum[FRACW]);

    qnan = {1'b0, {EXPW{1'b1}}, 1'b1,
            {(FRACW-1){1'b0}}};

    if (nan_a | nan_b | (inf_a & zero_b)
        | (inf_b & zero_a)) begin
      res    = qnan;
      res_cc = 4'b0000;
    end else if (inf_a | inf_b) begin
      res    = {sgn, {EXPW{1'b1}}, {FRACW{1'b0}}};
      res_cc = {2'b00, sgn, 1'b0};
    end else if (zero_a | zero_b) begin
      res    = {sgn, {(W-1){1'b0}}};
      res_cc = {2'b10, sgn, 1'b0};
    end else if (e_n < ONE) begin
      res    = {sgn, {(W-1){1'b0}}};
      res_cc = {1'b1, nz, sgn, 1'b0};
    end else if (e_r >= EMAXS) begin
      res    = {sgn, {EXPW{1'b1}}, {FRACW{1'b0}}};
      res_cc = {2'b01, sgn, 1'b1};
    end else begin
      res    = {sgn, e_r[EXPW-1:0], rsum[FRACW-1:0]};
      res_cc = {1'b0, inex, sgn, 1'b0};
    end
  end

  // Next-state for the control FSM and the shift-add datapath.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    cc_d     = cc_q;
    done_d   = done_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        done_d = (state_q == DONE);
        if (start) begin
          a_d      = fpuIn1;
          b_d      = fpuIn2;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = PW'(man_in1);
          mplier_d = man_in2;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(FRACW)) state_d = ROUND;
      end
      ROUND: begin
        out_d   = res;
        cc_d    = res_cc;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous abort on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      cc_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      cc_q     <= cc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_fpu_mul_param.sv
// Directed bench for fpu_mul_param.
// Runs fp16 and fp32 instances against hand-computed products.
module tb_fpu_mul_param;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in1, in2, out16;
  logic        done, busy;
  logic [3:0]  cc;

  logic        start32;
  logic [31:0] a32, b32, out32;
  logic        done32, busy32;
  logic [3:0]  cc32;

  int tests;
  int fails;

  fpu_mul_param #(.EXPW(5), .FRACW(10)) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .fpuIn1    (in1),
    .fpuIn2    (in2),
    .fpuOut    (out16),
    .done      (done),
    .busy      (busy),
    .condCodes (cc)
  );

  fpu_mul_param #(.EXPW(8), .FRACW(23)) dut32 (
    .clock     (clk),
    .reset     (reset),
    .start     (start32),
    .fpuIn1    (a32),
    .fpuIn2    (b32),
    .fpuOut    (out32),
    .done      (done32),
    .busy      (busy32),
    .condCodes (cc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an fp16 op; n = edges until done, d0 = done right after start.
  task automatic run16(input logic [15:0] a,
                       input logic [15:0] b,
                       output int n, output logic d0);
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done;
    in1 = 16'hFFFF;
    in2 = 16'hFFFF;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    if (!done) n = -1;
  endtask

  task automatic run32(input logic [31:0] a,
                       input logic [31:0] b,
                       output int n);
    @(negedge clk);
    a32 = a;
    b32 = b;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    a32 = '1;
    b32 = '1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done32) break;
    end
    if (!done32) n = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out16, done, busy, cc} !== 22'd0) begin
      fails++;
      $display("FAIL reset16 got %h/%b/%b/%b want 0",
               out16, done, busy, cc);
    end
    tests++;
    if ({out32, done32, busy32, cc32} !== 38'd0) begin
      fails++;
      $display("FAIL reset32 got %h/%b/%b/%b want 0",
               out32, done32, busy32, cc32);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    logic d0;
    run16(16'h3E00, 16'h4000, n, d0);
    tests++;
    if (n !== 13) begin
      fails++;
      $display("FAIL basic_lat got %0d want 13", n);
    end
    tests++;
    if (out16 !== 16'h4200 || cc !== 4'b0000) begin
      fails++;
      $display("FAIL basic got %h cc %b want 4200 cc 0000",
               out16, cc);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || out16 !== 16'h4200) begin
      fails++;
      $display("FAIL basic_hold got %b %h want 1 4200",
               done, out16);
    end
  endtask

  task automatic test_rne;
    int n;
    logic d0;
    run16(16'h3C01, 16'h3C01, n, d0);
    tests++;
    if (out16 !== 16'h3C02 || cc !== 4'b0100) begin
      fails++;
      $display("FAIL rne got %h cc %b want 3c02 cc 0100",
               out16, cc);
    end
  endtask

  task automatic test_range;
    int n;
    logic d0;
    run16(16'h7BFF, 16'h4000, n, d0);
    tests++;
    if (out16 !== 16'h7C00 || cc !== 4'b0101) begin
      fails++;
      $display("FAIL ovf got %h cc %b want 7c00 cc 0101",
               out16, cc);
    end
    run16(16'h0400, 16'h0400, n, d0);
    tests++;
    if (out16 !== 16'h0000 || cc !== 4'b1100) begin
      fails++;
      $display("FAIL unf got %h cc %b want 0000 cc 1100",
               out16, cc);
    end
    run16(16'h8000, 16'h3C00, n, d0);
    tests++;
    if (out16 !== 16'h8000 || cc !== 4'b1010) begin
      fails++;
      $display("FAIL negzero got %h cc %b want 8000 cc 1010",
               out16, cc);
    end
  endtask

  task automatic test_special;
    int n;
    logic d0;
    run16(16'h7C00, 16'h0000, n, d0);
    tests++;
    if (d0 !== 1'b0 || n !== 13) begin
      fails++;
      $display("FAIL b2b_done got d0=%b n=%0d want 0 13",
               d0, n);
    end
    tests++;
    if (out16 !== 16'h7E00 || cc !== 4'b0000) begin
      fails++;
      $display("FAIL inf0 got %h cc %b want 7e00 cc 0000",
               out16, cc);
    end
    run16(16'hFC01, 16'h3C00, n, d0);
    tests++;
    if (out16 !== 16'h7E00 || cc !== 4'b0000 || d0 !== 1'b0) begin
      fails++;
      $display("FAIL nan got %h cc %b d0 %b want 7e00 0000 0",
               out16, cc, d0);
    end
    run16(16'h7C00, 16'hC000, n, d0);
    tests++;
    if (out16 !== 16'hFC00 || cc !== 4'b0010 || n !== 13) begin
      fails++;
      $display("FAIL neginf got %h cc %b n %0d want fc00 0010 13",
               out16, cc, n);
    end
  endtask

  task automatic test_abort;
    int n;
    logic d0;
    @(negedge clk);
    in1 = 16'h3E00;
    in2 = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy got %b/%b want 1/0", busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || out16 !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort got %b %h %b want 0 0000 0",
               done, out16, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle got %b/%b want 0/0", done, busy);
    end
    run16(16'h3E00, 16'h4000, n, d0);
    tests++;
    if (n !== 13 || out16 !== 16'h4200) begin
      fails++;
      $display("FAIL abort_restart got n=%0d %h want 13 4200",
               n, out16);
    end
  endtask

  task automatic test_fp32;
    int n;
    run32(32'h3FC00000, 32'h40000000, n);
    tests++;
    if (n !== 26) begin
      fails++;
      $display("FAIL fp32_lat got %0d want 26", n);
    end
    tests++;
    if (out32 !== 32'h40400000 || cc32 !== 4'b0000) begin
      fails++;
      $display("FAIL fp32 got %h cc %b want 40400000 0000",
               out32, cc32);
    end
    run32(32'h00800000, 32'h3F000000, n);
    tests++;
    if (out32 !== 32'h0 || cc32 !== 4'b1100) begin
      fails++;
      $display("FAIL fp32_unf got %h cc %b want 0 1100",
               out32, cc32);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    start32 = 1'b0;
    in1     = '0;
    in2     = '0;
    a32     = '0;
    b32     = '0;
    test_reset();
    test_basic();
    test_rne();
    test_range();
    test_special();
    test_abort();
    test_fp32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_mul_param.md
Name: fpu_mul_param

Overview:
- Parametrised IEEE-754-style floating-point multiply coprocessor. It is the successor to the fixed fp16 multiplier.
- Generic exponent and fraction widths.
- Internal shift-add significand multiplier.
- Round-to-nearest-even.
- Full handling of special operands (zero, inf, NaN, subnormal).
- Correct exponent overflow and underflow handling.
- Re-triggerable start/done handshake.
- Sits beside the FPU add/sub units behind the same start/done/condCodes coprocessor interface.

Parameters:
- EXPW, 5, exponent field width (bias = 2^(EXPW-1)-1).
- FRACW, 10, stored fraction width (significand is FRACW+1 bits including the hidden bit).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- fpuIn1  in  1+EXPW+FRACW  operand A, packed {sign, exp, frac}.
- fpuIn2  in  1+EXPW+FRACW  operand B, packed {sign, exp, frac}.
- fpuOut  out  1+EXPW+FRACW  registered product; valid while done=1.
- done  out  1  high in DONE state until the next accepted start or reset.
- busy  out  1  high in MUL and ROUND states.
- condCodes  out  4  {Z,C,N,V}, registered with fpuOut.

Behaviour:
- Reset (synchronous): state=IDLE; fpuOut=0, done=0, busy=0, condCodes=0, iteration counter=0. Reset asserted in any state, including mid-MUL, aborts the operation with no partial result.
- State IDLE:
  - start=1 → capture both operands into internal registers, clear the accumulator, counter=0, go to MUL.
  - Otherwise stay in IDLE.
- State MUL: one multiplier bit per cycle (LSB first).
  - Add the shifted multiplicand into a 2*(FRACW+1)-bit accumulator.
  - After FRACW+1 cycles (counter==FRACW), go to ROUND.
- State ROUND: one cycle. Normalise, round, apply special cases, register fpuOut and condCodes, go to DONE.
- State DONE:
  - done=1; results held stable.
  - start=1 → capture new operands, done drops, go to MUL (back-to-back operation, no IDLE gap).
- Latency: start sampled at edge k → done=1 after edge k+FRACW+3 (13 cycles for fp16, 26 for fp32).
- Latency is identical for special operands; there is no early exit.
- start is ignored while busy=1. Operand inputs may change freely after capture.
- Operand decode:
  - exp==0: subnormal; hidden bit 0, effective exponent 1.
  - Otherwise hidden bit 1.
- Sign: signA XOR signB, including for zero and inf results. NaN results are always positive.
- Exponent arithmetic: signed, EXPW+2 bits: eA + eB - bias, +1 if the product MSB is set. The exponent must never wrap.
- Normalise:
  - The product has 2 integer bits; shift right 1 if the top bit is set.
  - For subnormal inputs, left-shift (leading-zero count) until normalised, decrementing the exponent.
- Rounding: RNE using guard, round and sticky (OR of all remaining low bits).
  - A round-up carry out of the fraction increments the exponent.
- Overflow (rounded exp ≥ 2^EXPW-1): result ±inf, V=1, C=1.
- Underflow (exp < 1 after normalise): flush to signed zero (no subnormal outputs); C=1 if the exact product ≠ 0.
- Special cases, highest priority first:
  - Either operand NaN → canonical quiet NaN {0, all-ones exp, 1 followed by zeros}.
  - inf×0 → quiet NaN.
  - inf×finite → ±inf.
  - 0×finite → ±0.
- condCodes:
  - Z = result is ±0.
  - C = inexact (rounding discarded nonzero bits, or flush/overflow).
  - N = fpuOut sign bit.
  - V = overflow to inf.
  - All four are 0 for a NaN result except N=0.

Test Plan:
- Default params, fpuIn1=0x3E00 (1.5), fpuIn2=0x4000 (2.0), start pulse → fpuOut=0x4200, condCodes=0000, done rises exactly 13 cycles after start.
- 0x3C01 × 0x3C01 → 0x3C02 (RNE drops 2^-20), C=1, Z=0, V=0.
- 0x7BFF × 0x4000 → 0x7C00, V=1, C=1. Then 0x0400 × 0x0400 → 0x0000, Z=1, C=1. Then 0x8000 × 0x3C00 → 0x8000, Z=1, N=1, C=0.
- 0x7C00 × 0x0000 → 0x7E00. Then 0xFC01 × 0x3C00 → 0x7E00. Then 0x7C00 × 0xC000 → 0xFC00, N=1. Each starts from DONE, back-to-back; done drops the cycle after start.
- Start 0x3E00 × 0x4000, pulse start again 4 cycles later (ignored), assert reset at cycle 6 → next cycle done=0, fpuOut=0, busy=0. A fresh start then yields 0x4200 after 13 cycles.
- EXPW=8, FRACW=23: 0x3FC00000 × 0x40000000 → 0x40400000 after 26 cycles. Also 0x00800000 × 0x3F000000 → 0x00000000, Z=1, C=1.
